// File: rtl/imm_gen_fifo_if.sv
// Handshake bundle for imm_gen_fifo: instruction/tag in, decoded immediate/tag out.
// master drives instructions and consumes results; slave is the FIFO itself.
interface imm_gen_fifo_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int TAG_W = 32
);
    logic                         in_valid;
    logic                         in_ready;
    logic [31:0]                  instruction;
    logic [TAG_W-1:0]             in_tag;
    logic                         out_valid;
    logic                         out_ready;
    logic [XLEN-1:0]              immediate;
    logic [2:0]                   imm_fmt;
    logic                         imm_unknown;
    logic [TAG_W-1:0]             out_tag;
    logic [$clog2(DEPTH+1)-1:0]   count;

    modport master (
        output in_valid, instruction, in_tag, out_ready,
        input  in_ready, out_valid, immediate, imm_fmt, imm_unknown, out_tag, count
    );

    modport slave (
        input  in_valid, instruction, in_tag, out_ready,
        output in_ready, out_valid, immediate, imm_fmt, imm_unknown, out_tag, count
    );
endinterface

// File: rtl/imm_gen_fifo.sv
// RV32I immediate decoder feeding a DEPTH-entry valid/ready FIFO with a pass-through tag.
// Optional macro IMM_GEN_SHAMT_EN: OP-IMM shifts yield the zero-extended shift amount.
module imm_gen_fifo #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int TAG_W = 32
) (
    input logic           clk,
    input logic           rst,
    imm_gen_fifo_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5
    } fmt_e;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        fmt_e             fmt;
        logic             unknown;
        logic [TAG_W-1:0] tag;
    } entry_t;

    logic [31:0]      inst;
    logic [31:0]      imm32;
    logic [XLEN-1:0]  dec_imm;
    fmt_e             dec_fmt;
    logic             dec_unknown;

    assign inst = bus.instruction;

    // Every format is first assembled as a signed 32-bit value, then widened.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        imm32       = '0;
        dec_fmt     = FMT_NONE;
        dec_unknown = 1'b0;
        unique case (inst[6:0])
            OP_IMM, OP_LOAD, OP_JALR: begin
                imm32   = {{20{inst[31]}}, inst[31:20]};
                dec_fmt = FMT_I;
            end
            OP_STORE: begin
                imm32   = {{20{inst[31]}}, inst[31:25], inst[11:7]};
                dec_fmt = FMT_S;
            end
            OP_BR: begin
                imm32   = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
                dec_fmt = FMT_B;
            end
            OP_LUI, OP_AUIPC: begin
                imm32   = {inst[31:12], 12'b0};
                dec_fmt = FMT_U;
            end
            OP_JAL: begin
                imm32   = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
                dec_fmt = FMT_J;
            end
            default: dec_unknown = 1'b1;
        endcase
    end

`ifdef IMM_GEN_SHAMT_EN
    logic [XLEN-1:0] shamt;
    logic            is_shift;

    // funct7 is excluded so SRAI reports the bare shift distance.
    always_comb begin
        shamt = '0;
        if (XLEN == 64) shamt[5:0] = inst[25:20];
        else            shamt[4:0] = inst[24:20];
    end

    assign is_shift = (inst[6:0] == OP_IMM) && (inst[13:12] == 2'b01);
    assign dec_imm  = is_shift ? shamt : XLEN'($signed(imm32));
`else
    assign dec_imm  = XLEN'($signed(imm32));
`endif

    entry_t            mem [DEPTH];
    entry_t            wr_entry;
    entry_t            head;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_q;
    logic              push;
    logic              pop;

    assign bus.in_ready  = (count_q != CNT_W'(DEPTH));
    assign bus.out_valid = (count_q != '0);
    assign bus.count     = count_q;

    assign push = bus.in_valid  && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    assign wr_entry = '{imm: dec_imm, fmt: dec_fmt, unknown: dec_unknown, tag: bus.in_tag};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register reading pre-edge values.
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage is not reset; count gates every read, so stale entries are never visible.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_entry;
    end

    // Head fields are forced to zero while empty so stale data never leaks out.
    assign head            = mem[rd_ptr];
    assign bus.immediate   = bus.out_valid ? head.imm     : '0;
    assign bus.imm_fmt     = bus.out_valid ? head.fmt     : FMT_NONE;
    assign bus.imm_unknown = bus.out_valid ? head.unknown : 1'b0;
    assign bus.out_tag     = bus.out_valid ? head.tag     : '0;
endmodule

// File: tb/tb_imm_gen_fifo.sv
// Self-checking bench for imm_gen_fifo: directed vectors plus random traffic vs a queue model.
// Expected shift immediates follow IMM_GEN_SHAMT_EN as defined for the build.
module tb_imm_gen_fifo;
    localparam int DEPTH = 4;

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        unk;
        logic [31:0] tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    imm_gen_fifo_if #(.XLEN(32), .DEPTH(DEPTH), .TAG_W(32)) b32();
    imm_gen_fifo_if #(.XLEN(64), .DEPTH(DEPTH), .TAG_W(32)) b64();

    imm_gen_fifo #(.XLEN(32), .DEPTH(DEPTH), .TAG_W(32)) u32 (.clk(clk), .rst(rst), .bus(b32));
    imm_gen_fifo #(.XLEN(64), .DEPTH(DEPTH), .TAG_W(32)) u64 (.clk(clk), .rst(rst), .bus(b64));

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // Immediate value computed as a signed integer from the field weights of each format.
    function automatic exp_t model(input logic [31:0] inst, input logic [31:0] tag, input int xlen);
        exp_t   e;
        longint v;
        e.fmt = 3'd0;
        e.unk = 1'b0;
        e.tag = tag;
        v     = 0;
        case (inst[6:0])
            7'h13, 7'h03, 7'h67: begin
                e.fmt = 3'd1;
                v = longint'(inst[30:20]) - (inst[31] ? 2048 : 0);
`ifdef IMM_GEN_SHAMT_EN
                if (inst[6:0] == 7'h13 && (inst[14:12] == 3'd1 || inst[14:12] == 3'd5))
                    v = (xlen == 64) ? longint'(inst[25:20]) : longint'(inst[24:20]);
`endif
            end
            7'h23: begin
                e.fmt = 3'd2;
                v = longint'(inst[30:25]) * 32 + longint'(inst[11:7]) - (inst[31] ? 2048 : 0);
            end
            7'h63: begin
                e.fmt = 3'd3;
                v = longint'(inst[7]) * 2048 + longint'(inst[30:25]) * 32
                  + longint'(inst[11:8]) * 2 - (inst[31] ? 4096 : 0);
            end
            7'h37, 7'h17: begin
                e.fmt = 3'd4;
                v = longint'(inst[30:12]) * 4096 - (inst[31] ? (longint'(1) << 31) : 0);
            end
            7'h6F: begin
                e.fmt = 3'd5;
                v = longint'(inst[19:12]) * 4096 + longint'(inst[20]) * 2048
                  + longint'(inst[30:21]) * 2 - (inst[31] ? (longint'(1) << 20) : 0);
            end
            default: e.unk = 1'b1;
        endcase
        e.imm = (xlen == 64) ? 64'(v) : {32'b0, 32'(v)};
        return e;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [6:0] ops [10];
        logic [31:0] r;
        ops = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F, 7'h33};
        r = $urandom;
        return {r[31:7], ops[$urandom_range(0, 9)]};
    endfunction

    task automatic check_head();
        check("count", 64'(b32.count), 64'(q.size()));
        check("in_ready", 64'(b32.in_ready), 64'(q.size() != DEPTH));
        check("out_valid", 64'(b32.out_valid), 64'(q.size() != 0));
        if (q.size() != 0) begin
            check("immediate", 64'(b32.immediate), q[0].imm);
            check("imm_fmt", 64'(b32.imm_fmt), 64'(q[0].fmt));
            check("imm_unknown", 64'(b32.imm_unknown), 64'(q[0].unk));
            check("out_tag", 64'(b32.out_tag), 64'(q[0].tag));
        end else begin
            check("empty_imm", 64'(b32.immediate), 64'd0);
            check("empty_tag", 64'(b32.out_tag), 64'd0);
            check("empty_fmt", 64'(b32.imm_fmt), 64'd0);
        end
    endtask

    // Inputs are set just after a negedge; outputs are checked before the rising edge.
    task automatic tick();
        logic push, pop;
        exp_t e;
        check_head();
        push = b32.in_valid && (q.size() < DEPTH);
        pop  = b32.out_ready && (q.size() != 0);
        e    = model(b32.instruction, b32.in_tag, 32);
        @(posedge clk);
        if (pop)  void'(q.pop_front());
        if (push) q.push_back(e);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] tag, input logic rdy);
        b32.in_valid    = v;
        b32.instruction = inst;
        b32.in_tag      = tag;
        b32.out_ready   = rdy;
    endtask

    task automatic push_check(input string name, input logic [31:0] inst,
                              input logic [31:0] exp_imm, input logic [2:0] exp_fmt,
                              input logic exp_unk);
        drive(1'b1, inst, $urandom, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        check({name, "_valid"}, 64'(b32.out_valid), 64'd1);
        check({name, "_imm"}, 64'(b32.immediate), 64'(exp_imm));
        check({name, "_fmt"}, 64'(b32.imm_fmt), 64'(exp_fmt));
        check({name, "_unk"}, 64'(b32.imm_unknown), 64'(exp_unk));
        b32.out_ready = 1'b1;
        tick();
        b32.out_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] srai_exp;
`ifdef IMM_GEN_SHAMT_EN
        srai_exp = 32'h0000_0003;
`else
        srai_exp = 32'h0000_0403;
`endif
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        b64.in_valid    = 1'b0;
        b64.instruction = 32'h0;
        b64.in_tag      = 32'h0;
        b64.out_ready   = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state, then the directed decode vectors.
        tick();
        push_check("addi", 32'hFFF0_0093, 32'hFFFF_FFFF, 3'd1, 1'b0);
        push_check("sw",   32'hFE11_2E23, 32'hFFFF_FFFC, 3'd2, 1'b0);
        push_check("beq",  32'h0000_0863, 32'h0000_0010, 3'd3, 1'b0);
        push_check("lui",  32'h1234_52B7, 32'h1234_5000, 3'd4, 1'b0);
        push_check("jal",  32'hFFDF_F06F, 32'hFFFF_FFFC, 3'd5, 1'b0);
        push_check("unk",  32'h0000_007F, 32'h0000_0000, 3'd0, 1'b1);
        push_check("srai", 32'h4030_D093, srai_exp,      3'd1, 1'b0);

        // Streaming with out_ready held high.
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, rand_inst(), 32'h200 + i, 1'b1);
            tick();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        tick();

        // Fill past full: tag 5 must be refused.
        for (int t = 1; t <= 5; t++) begin
            drive(1'b1, rand_inst(), t, 1'b0);
            tick();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        check("full_count", 64'(b32.count), 64'd4);
        check("full_in_ready", 64'(b32.in_ready), 64'd0);
        check("full_head_tag", 64'(b32.out_tag), 64'd1);
        b32.out_ready = 1'b1;
        repeat (4) tick();
        check("drained_count", 64'(b32.count), 64'd0);

        // Refill across the pointer wrap, then drain.
        for (int t = 0; t < 3; t++) begin
            drive(1'b1, rand_inst(), 32'h300 + t, 1'b0);
            tick();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        repeat (3) tick();

        // Hold occupancy at two under simultaneous push and pop.
        for (int t = 0; t < 2; t++) begin
            drive(1'b1, rand_inst(), 32'h400 + t, 1'b0);
            tick();
        end
        for (int t = 2; t < 8; t++) begin
            drive(1'b1, rand_inst(), 32'h400 + t, 1'b1);
            tick();
            check("hold_count", 64'(b32.count), 64'd2);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        repeat (2) tick();

        // Random traffic against the queue model.
        for (int i = 0; i < 120; i++) begin
            drive(1'($urandom_range(0, 1)), rand_inst(), $urandom, 1'($urandom_range(0, 1)));
            tick();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        repeat (DEPTH) tick();

        // 64-bit instance: I and U sign extension from bit 31.
        b64.in_valid    = 1'b1;
        b64.instruction = 32'hFFF0_0093;
        b64.in_tag      = 32'hA5;
        tick();
        b64.instruction = 32'h8000_02B7;
        tick();
        b64.in_valid = 1'b0;
        check("x64_addi_imm", b64.immediate, 64'hFFFF_FFFF_FFFF_FFFF);
        check("x64_addi_fmt", 64'(b64.imm_fmt), 64'd1);
        b64.out_ready = 1'b1;
        tick();
        check("x64_lui_imm", b64.immediate, 64'hFFFF_FFFF_8000_0000);
        check("x64_lui_fmt", 64'(b64.imm_fmt), 64'd4);
        tick();
        b64.out_ready = 1'b0;
        check("x64_empty", 64'(b64.out_valid), 64'd0);

        // Asynchronous reset with three entries queued, between clock edges.
        for (int t = 0; t < 3; t++) begin
            drive(1'b1, rand_inst(), 32'h500 + t, 1'b0);
            tick();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        check("pre_rst_count", 64'(b32.count), 64'd3);
        #2 rst = 1'b1;
        #1;
        check("rst_out_valid", 64'(b32.out_valid), 64'd0);
        check("rst_count", 64'(b32.count), 64'd0);
        check("rst_in_ready", 64'(b32.in_ready), 64'd1);
        check("rst_imm", 64'(b32.immediate), 64'd0);
        check("rst_tag", 64'(b32.out_tag), 64'd0);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        tick();
        drive(1'b1, 32'hFFF0_0093, 32'h600, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
